// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rrarb3_1.sv
// Three-way round-robin arbiter with registered one-hot grant and hold-limit preemption.
// State | meaning: IDLE | no grant outstanding ; BUSY | exactly one Gn held by owner gid_q
module gf180mcu_fd_sc_mcu9t5v0__rrarb3_1 #(
    parameter int MAXHOLD = 8
) (
    input  logic       CLK,
    input  logic       RN,
    input  logic       EN,
    input  logic       R1,
    input  logic       R2,
    input  logic       R3,
    output logic       G1,
    output logic       G2,
    output logic       G3,
    output logic       GV,
    output logic [1:0] GID
);

    localparam int HCW = (MAXHOLD < 2) ? 1 : $clog2(MAXHOLD + 1);
    localparam logic [HCW-1:0] HC_MAX = HCW'(MAXHOLD);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_q, state_d;
    logic [1:0]     last_q, last_d;
    logic [1:0]     gid_q, gid_d;
    logic [HCW-1:0] hc_q, hc_d;
    logic [2:0]     g_q, g_d;
    logic           gv_q, gv_d;

    logic [2:0] req;
    logic [1:0] cand1, cand2, pick;
    logic       owner_req, other_req, hc_at_max, preempt;

    assign req = {R3, R2, R1};

    function automatic logic [1:0] next_id(input logic [1:0] v);
        return (v == 2'd3) ? 2'd1 : v + 2'd1;
    endfunction

    function automatic logic req_of(input logic [2:0] r, input logic [1:0] id);
        logic res;
        case (id)
            2'd1:    res = r[0];
            2'd2:    res = r[1];
            2'd3:    res = r[2];
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] id);
        logic [2:0] res;
        case (id)
            2'd1:    res = 3'b001;
            2'd2:    res = 3'b010;
            2'd3:    res = 3'b100;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    always_comb begin
        cand1     = next_id(last_q);
        cand2     = next_id(cand1);
        owner_req = req_of(req, gid_q);
        other_req = |(req & ~onehot(gid_q));
        hc_at_max = (hc_q == HC_MAX);
        // MAXHOLD of zero disables preemption entirely
        preempt   = (MAXHOLD > 0) && hc_at_max && other_req;
        if (req_of(req, cand1))      pick = cand1;
        else if (req_of(req, cand2)) pick = cand2;
        else                         pick = last_q;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gid_d   = gid_q;
        hc_d    = hc_q;
        case (state_q)
            IDLE: begin
                if (EN && (|req)) begin
                    state_d = BUSY;
                    gid_d   = pick;
                    last_d  = pick;
                    hc_d    = '0;
                end
            end
            BUSY: begin
                // A release always lands in IDLE, which enforces the one-cycle gap
                if (!owner_req || preempt) begin
                    state_d = IDLE;
                    gid_d   = 2'd0;
                    hc_d    = '0;
                end else if (!hc_at_max) begin
                    hc_d = hc_q + HCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gid_d   = 2'd0;
                hc_d    = '0;
            end
        endcase
        g_d  = onehot(gid_d);
        gv_d = (gid_d != 2'd0);
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            gid_q   <= 2'd0;
            hc_q    <= '0;
            g_q     <= 3'b000;
            gv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            hc_q    <= hc_d;
            g_q     <= g_d;
            gv_q    <= gv_d;
        end
    end

    assign G1  = g_q[0];
    assign G2  = g_q[1];
    assign G3  = g_q[2];
    assign GV  = gv_q;
    assign GID = gid_q;

endmodule
